fifo_level: RTL and testbench
=============================

# fifo_level

Parametrised synchronous FIFO that supersedes the basic FIFO buffer. It adds an occupancy count, programmable almost-full and almost-empty thresholds, and overflow/underflow error pulses. It fixes simultaneous read/write handling at the empty and full boundaries. It sits between a producer and a consumer in the same clock domain, typically a UART or other stream datapath, where the consumer needs early back-pressure and level information.

## Interface
- B, 8, data word width in bits
- W, 4, address bits; depth D = 2**W
- AE, 2, almost-empty threshold (0 ≤ AE < D)
- AF, 2**W-2, almost-full threshold (0 < AF ≤ D)

- clk  input  1  clock, rising edge
- reset  input  1  reset, asynchronous, active-high
- rd  input  1  read request; pops the current head word
- wr  input  1  write request; pushes w_data
- w_data  input  B  write data
- r_data  output  B  head word (show-ahead, combinational from storage)
- empty  output  1  registered, count == 0
- full  output  1  registered, count == D
- almost_empty  output  1  registered, count ≤ AE
- almost_full  output  1  registered, count ≥ AF
- count  output  W+1  registered occupancy, 0..D
- overflow  output  1  registered one-cycle pulse: write rejected
- underflow  output  1  registered one-cycle pulse: read rejected

## Operation
- State: w_ptr, r_ptr (W bits, wrap modulo D), count (W+1 bits), flags. Storage is D×B, written at w_ptr; contents are not reset.
- Effective operations per cycle:
  - do_wr = wr & (~full | rd)
  - do_rd = rd & ~empty
- Cases:
  - wr only, not full: store w_data, w_ptr+1, count+1.
  - rd only, not empty: r_ptr+1, count−1.
  - wr & rd, not empty and not full: both pointers advance, count unchanged.
  - wr & rd while empty: write only, count→1. The read is rejected and underflow pulses.
  - wr & rd while full: read and write both take effect, count stays D, full stays 1.
  - wr while full, no rd: write dropped, overflow pulses, state unchanged.
  - rd while empty: underflow pulses, state unchanged.
- All flags are computed from next_count and registered, so they are always consistent with count in the same cycle.
- Pointer wrap: D−1 → 0 with no special casing.
- r_data = storage[r_ptr]. When empty, its value is undefined; the bench must not check it.
- Reset values: w_ptr = r_ptr = 0, count = 0, empty = 1, full = 0, almost_empty = 1, almost_full = 0, overflow = 0, underflow = 0.
- Reset asserted mid-operation clears all of the above immediately. Stored words are lost logically.

## Timing
- Write-to-read latency: a word written at edge N is visible on r_data, with empty = 0, after edge N.
- A read at edge N presents the next word on r_data after edge N.
- All flag and count updates occur on the same edge as the causing operation. There is no lookahead.
- overflow and underflow are high for exactly the cycle following the offending edge, and low otherwise.
- Throughput: one write and one read per cycle in every state, with the exceptions above.

## Structure
- Shared header fifo_defs.vh holds the default B/W/AE/AF values and the clog2-style depth constant, reused by producers and consumers.
- Sub-module fifo_reg_file: D×B register array with a synchronous write port (we, w_addr, w_data) and an asynchronous read port (r_addr, r_data).
- The top level holds the pointer/count control and flag registers.

## Test plan
- Reset then idle: empty = 1, almost_empty = 1, count = 0, full = 0, overflow = underflow = 0.
- Write 0x01..0x10 (16 words, W = 4):
  - count steps 1..16.
  - almost_empty drops after the 3rd write.
  - almost_full rises at count = 14.
  - full rises after the 16th write.
  - A 17th write with wr only pulses overflow and leaves count at 16.
- Read all 16 words: r_data sequence is 0x01..0x10, then empty = 1. One more rd pulses underflow and leaves count at 0.
- Simultaneous rd & wr:
  - When empty with w_data = 0xAA: count = 1, r_data = 0xAA, underflow pulses.
  - When full: count stays 16, the oldest word is popped, the new word lands at the tail, and no overflow occurs.
- Wrap-around: 100 cycles of random wr/rd against a reference queue model. Pointers wrap multiple times, and data order and count match every cycle.
- Reset asserted mid-stream with count = 7: all outputs return to their reset values asynchronously, before the next clock edge.

Source files
------------

// File: rtl/fifo_level_pkg.sv
// fifo_level_pkg: default FIFO geometry and the per-cycle operation encoding
// shared by the FIFO core and by the producers and consumers that size against it.
`default_nettype none

package fifo_level_pkg;

   localparam int unsigned FIFO_B_DEFAULT  = 8;
   localparam int unsigned FIFO_W_DEFAULT  = 4;
   localparam int unsigned FIFO_D_DEFAULT  = 1 << FIFO_W_DEFAULT;
   localparam int unsigned FIFO_AE_DEFAULT = 2;
   localparam int unsigned FIFO_AF_DEFAULT = FIFO_D_DEFAULT - 2;

   // Encoding is {do_rd, do_wr} so the cast below is a straight reinterpretation.
   typedef enum logic [1:0] {
      OP_IDLE = 2'b00,
      OP_WR   = 2'b01,
      OP_RD   = 2'b10,
      OP_RW   = 2'b11
   } fifo_op_e;

   function automatic fifo_op_e fifo_op(input logic do_wr, input logic do_rd);
      return fifo_op_e'({do_rd, do_wr});
   endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_level_reg_file.sv
// fifo_level_reg_file: D x B storage array, synchronous write port and
// asynchronous (show-ahead) read port. Contents are intentionally not reset.
`default_nettype none

module fifo_level_reg_file #(
   parameter int B = 8,
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         we,
   input  logic [W-1:0] w_addr,
   input  logic [B-1:0] w_data,
   input  logic [W-1:0] r_addr,
   output logic [B-1:0] r_data
);

   logic [B-1:0] mem_q [2**W];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[w_addr] <= w_data;
      end
   end

   assign r_data = mem_q[r_addr];

endmodule

`default_nettype wire

// File: rtl/fifo_level.sv
// fifo_level: synchronous FIFO with occupancy count, almost-empty/almost-full
// thresholds and one-cycle overflow/underflow pulses; all flags are registered.
`default_nettype none

module fifo_level
   import fifo_level_pkg::*;
#(
   parameter int B  = FIFO_B_DEFAULT,
   parameter int W  = FIFO_W_DEFAULT,
   parameter int AE = FIFO_AE_DEFAULT,
   parameter int AF = (2**W) - 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         rd,
   input  logic         wr,
   input  logic [B-1:0] w_data,
   output logic [B-1:0] r_data,
   output logic         empty,
   output logic         full,
   output logic         almost_empty,
   output logic         almost_full,
   output logic [W:0]   count,
   output logic         overflow,
   output logic         underflow
);

   localparam logic [W:0] DEPTH_C = (W+1)'(2**W);
   localparam logic [W:0] AE_C    = (W+1)'(AE);
   localparam logic [W:0] AF_C    = (W+1)'(AF);

   logic [W-1:0] w_ptr_q, w_ptr_d;
   logic [W-1:0] r_ptr_q, r_ptr_d;
   logic [W:0]   count_q, count_d;
   logic         empty_q, empty_d;
   logic         full_q, full_d;
   logic         almost_empty_q, almost_empty_d;
   logic         almost_full_q, almost_full_d;
   logic         overflow_q, overflow_d;
   logic         underflow_q, underflow_d;
   logic         do_wr, do_rd;
   fifo_op_e     op;

   // A write into a full FIFO is accepted when a read frees the head slot in
   // the same cycle; a read from an empty FIFO never sees the concurrent write.
   assign do_wr = wr & (~full_q | rd);
   assign do_rd = rd & ~empty_q;
   assign op    = fifo_op(do_wr, do_rd);

   always_comb begin
      w_ptr_d = w_ptr_q;
      r_ptr_d = r_ptr_q;
      count_d = count_q;
      case (op)
         OP_WR: begin
            w_ptr_d = w_ptr_q + W'(1);
            count_d = count_q + (W+1)'(1);
         end
         OP_RD: begin
            r_ptr_d = r_ptr_q + W'(1);
            count_d = count_q - (W+1)'(1);
         end
         OP_RW: begin
            w_ptr_d = w_ptr_q + W'(1);
            r_ptr_d = r_ptr_q + W'(1);
         end
         OP_IDLE: begin
            count_d = count_q;
         end
      endcase

      empty_d        = (count_d == '0);
      full_d         = (count_d == DEPTH_C);
      almost_empty_d = (count_d <= AE_C);
      almost_full_d  = (count_d >= AF_C);
      overflow_d     = wr & full_q & ~rd;
      underflow_d    = rd & empty_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         w_ptr_q        <= '0;
         r_ptr_q        <= '0;
         count_q        <= '0;
         empty_q        <= 1'b1;
         full_q         <= 1'b0;
         almost_empty_q <= 1'b1;
         almost_full_q  <= 1'b0;
         overflow_q     <= 1'b0;
         underflow_q    <= 1'b0;
      end else begin
         w_ptr_q        <= w_ptr_d;
         r_ptr_q        <= r_ptr_d;
         count_q        <= count_d;
         empty_q        <= empty_d;
         full_q         <= full_d;
         almost_empty_q <= almost_empty_d;
         almost_full_q  <= almost_full_d;
         overflow_q     <= overflow_d;
         underflow_q    <= underflow_d;
      end
   end

   fifo_level_reg_file #(
      .B (B),
      .W (W)
   ) u_reg_file (
      .clk    (clk),
      .we     (do_wr),
      .w_addr (w_ptr_q),
      .w_data (w_data),
      .r_addr (r_ptr_q),
      .r_data (r_data)
   );

   assign count        = count_q;
   assign empty        = empty_q;
   assign full         = full_q;
   assign almost_empty = almost_empty_q;
   assign almost_full  = almost_full_q;
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;

endmodule

`default_nettype wire

// File: tb/tb_fifo_level.sv
// tb_fifo_level: directed vector table plus hand-written corner sequences and a
// queue-referenced random phase for the fifo_level FIFO (B=8, W=4, AE=2, AF=14).
`default_nettype none

module tb_fifo_level;

   logic       clk;
   logic       reset;
   logic       rd;
   logic       wr;
   logic [7:0] w_data;
   logic [7:0] r_data;
   logic       empty, full, almost_empty, almost_full, overflow, underflow;
   logic [4:0] count;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic       rd;
      logic       wr;
      logic [7:0] wd;
      logic [4:0] cnt;
      logic       emp;
      logic       ful;
      logic       ae;
      logic       af;
      logic       ov;
      logic       un;
      logic       chk;
      logic [7:0] rdata;
   } vec_t;

   vec_t vecs[$];
   logic [7:0] model_q[$];

   fifo_level #(
      .B  (8),
      .W  (4),
      .AE (2),
      .AF (14)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .rd           (rd),
      .wr           (wr),
      .w_data       (w_data),
      .r_data       (r_data),
      .empty        (empty),
      .full         (full),
      .almost_empty (almost_empty),
      .almost_full  (almost_full),
      .count        (count),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int actual, input int expected);
      n_checks++;
      if (actual != expected) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   task automatic chk_all(input string tag, input logic [4:0] cnt, input logic emp,
                          input logic ful, input logic ae, input logic af,
                          input logic ov, input logic un, input logic chk_d,
                          input logic [7:0] rdata);
      chk({tag, ".count"}, int'(count), int'(cnt));
      chk({tag, ".empty"}, int'(empty), int'(emp));
      chk({tag, ".full"}, int'(full), int'(ful));
      chk({tag, ".almost_empty"}, int'(almost_empty), int'(ae));
      chk({tag, ".almost_full"}, int'(almost_full), int'(af));
      chk({tag, ".overflow"}, int'(overflow), int'(ov));
      chk({tag, ".underflow"}, int'(underflow), int'(un));
      if (chk_d) chk({tag, ".r_data"}, int'(r_data), int'(rdata));
   endtask

   task automatic add(input logic r, input logic w, input logic [7:0] wd,
                      input logic [4:0] cnt, input logic emp, input logic ful,
                      input logic ae, input logic af, input logic ov, input logic un,
                      input logic c, input logic [7:0] rdv);
      vec_t v;
      v.rd = r; v.wr = w; v.wd = wd; v.cnt = cnt; v.emp = emp; v.ful = ful;
      v.ae = ae; v.af = af; v.ov = ov; v.un = un; v.chk = c; v.rdata = rdv;
      vecs.push_back(v);
   endtask

   // Drive one cycle of inputs, take the edge, sample 1 time unit later.
   task automatic step(input logic r, input logic w, input logic [7:0] wd);
      rd = r; wr = w; w_data = wd;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic       r, w, exp_ov, exp_un, dw, dr;
      logic [7:0] d;
      logic [4:0] c;

      reset = 1'b1; rd = 1'b0; wr = 1'b0; w_data = 8'h00;

      // Table: fill to full, overflow, drain, underflow, rd&wr while empty.
      for (int k = 1; k <= 16; k++) begin
         add(0, 1, 8'(k), 5'(k), 0, (k == 16), (k <= 2), (k >= 14), 0, 0, 1, 8'h01);
      end
      add(0, 1, 8'h77, 5'd16, 0, 1, 0, 1, 1, 0, 1, 8'h01);
      for (int k = 1; k <= 16; k++) begin
         c = 5'(16 - k);
         add(1, 0, 8'h00, c, (c == 0), 0, (c <= 2), (c >= 14), 0, 0, (c != 0), 8'(k + 1));
      end
      add(1, 0, 8'h00, 5'd0, 1, 0, 1, 0, 0, 1, 0, 8'h00);
      add(0, 0, 8'h00, 5'd0, 1, 0, 1, 0, 0, 0, 0, 8'h00);
      add(1, 1, 8'hAA, 5'd1, 0, 0, 1, 0, 0, 1, 1, 8'hAA);
      add(0, 0, 8'h00, 5'd1, 0, 0, 1, 0, 0, 0, 1, 8'hAA);

      repeat (3) @(posedge clk);
      #1;
      chk_all("reset", 5'd0, 1, 0, 1, 0, 0, 0, 0, 8'h00);
      reset = 1'b0;
      step(0, 0, 8'h00);
      chk_all("idle", 5'd0, 1, 0, 1, 0, 0, 0, 0, 8'h00);

      foreach (vecs[i]) begin
         step(vecs[i].rd, vecs[i].wr, vecs[i].wd);
         chk_all($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].emp, vecs[i].ful,
                 vecs[i].ae, vecs[i].af, vecs[i].ov, vecs[i].un, vecs[i].chk, vecs[i].rdata);
      end

      // Contents now [AA]; fill to 16 with B1..BF, then rd&wr while full.
      for (int k = 1; k <= 15; k++) step(0, 1, 8'hB0 + 8'(k));
      chk_all("fill2", 5'd16, 0, 1, 0, 1, 0, 0, 1, 8'hAA);
      step(1, 1, 8'hCC);
      chk_all("full_rw", 5'd16, 0, 1, 0, 1, 0, 0, 1, 8'hB1);
      for (int k = 1; k <= 15; k++) begin
         step(1, 0, 8'h00);
         if (k < 15) chk($sformatf("drain%0d.r_data", k), int'(r_data), int'(8'hB1 + 8'(k)));
      end
      chk("drain_tail.r_data", int'(r_data), int'(8'hCC));
      chk("drain_tail.count", int'(count), 1);
      step(1, 0, 8'h00);
      chk_all("drained", 5'd0, 1, 0, 1, 0, 0, 0, 0, 8'h00);

      // Random traffic against a reference queue; pointers wrap several times.
      model_q.delete();
      for (int cyc = 0; cyc < 100; cyc++) begin
         r = ($urandom_range(99) < 45);
         w = ($urandom_range(99) < 55);
         d = 8'($urandom);
         exp_ov = w && (model_q.size() == 16) && !r;
         exp_un = r && (model_q.size() == 0);
         dw = w && ((model_q.size() < 16) || r);
         dr = r && (model_q.size() > 0);
         if (dr) void'(model_q.pop_front());
         if (dw) model_q.push_back(d);
         step(r, w, d);
         c = 5'(model_q.size());
         chk_all($sformatf("rnd%0d", cyc), c, (c == 0), (c == 16), (c <= 2), (c >= 14),
                 exp_ov, exp_un, (c != 0), (c != 0) ? model_q[0] : 8'h00);
      end

      // Bring to count 7, then assert reset between edges.
      rd = 1'b0; wr = 1'b0;
      reset = 1'b1;
      #2;
      reset = 1'b0;
      for (int k = 0; k < 7; k++) step(0, 1, 8'h40 + 8'(k));
      chk_all("pre_rst", 5'd7, 0, 0, 0, 0, 0, 0, 1, 8'h40);
      rd = 1'b0; wr = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      chk_all("async_rst", 5'd0, 1, 0, 1, 0, 0, 0, 0, 8'h00);
      #2;
      reset = 1'b0;
      step(0, 1, 8'h5A);
      chk_all("post_rst", 5'd1, 0, 0, 1, 0, 0, 0, 1, 8'h5A);
      step(0, 0, 8'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
